// File: rtl/mod_arith_pkg.sv
// Shared definitions for the chunked modular add/subtract datapath.
// Holds operand/chunk geometry, the serial FSM state type and the chunk type.
package mod_arith_pkg;

    localparam int unsigned OP_W       = 255;
    localparam int unsigned CHUNK_W    = 64;
    localparam int unsigned NUM_CHUNKS = 4;
    // Internal word carries one extra bit above the operand so the borrow is visible.
    localparam int unsigned WORD_W     = NUM_CHUNKS * CHUNK_W;

    typedef enum logic [1:0] {
        StIdle,
        StSub,
        StAdd,
        StDone
    } mod_state_e;

    typedef enum logic {
        ModeAdd = 1'b0,
        ModeSub = 1'b1
    } addsub_mode_e;

    typedef logic [CHUNK_W-1:0] chunk_t;

endpackage

// File: rtl/chunk_addsub.sv
// Combinational CHUNK_W-bit adder/subtractor shared by both serial phases.
// Ports:
//   mode   - ModeAdd: result = a + b + cin;  ModeSub: result = a - b - cin
//   a, b   - chunk operands
//   cin    - carry-in (add) or borrow-in (sub)
//   result - low CHUNK_W bits of the operation
//   cout   - carry-out (add) or borrow-out (sub)
module chunk_addsub
    import mod_arith_pkg::*;
(
    input  addsub_mode_e mode,
    input  chunk_t       a,
    input  chunk_t       b,
    input  logic         cin,
    output chunk_t       result,
    output logic         cout
);

    logic [CHUNK_W:0] full;

    // In subtract mode the extra top bit goes to 1 exactly when the result is negative.
    always_comb begin
        if (mode == ModeSub) begin
            full = {1'b0, a} - {1'b0, b} - {{CHUNK_W{1'b0}}, cin};
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{CHUNK_W{1'b0}}, cin};
        end
    end

    assign result = full[CHUNK_W-1:0];
    assign cout   = full[CHUNK_W];

endmodule

// File: rtl/mod_sub_serial.sv
// Multi-cycle modular subtractor: out = (a - b) mod p, 64-bit chunks, LSB first.
// SUB phase computes a - b over NUM_CHUNKS cycles; if it borrows, ADD phase adds p.
// Optional macro MOD_SUB_CONST_TIME_EN: ADD phase always runs (adding 0 when no
// borrow occurred) so latency does not depend on the operands.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake (in_ready high only when idle)
//   a, b, p             - minuend, subtrahend, modulus
//   out_valid/out_ready - result handshake (result held until accepted)
//   out                 - (a - b) mod p
//   wrapped             - p was added because a < b
module mod_sub_serial
    import mod_arith_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic [OP_W-1:0] p,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out,
    output logic            wrapped
);

    localparam int unsigned    CNT_W    = $clog2(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

    mod_state_e        state_q, state_d;
    logic [WORD_W-1:0] a_sr, b_sr, p_sr, diff_sr;
    logic [CNT_W-1:0]  cnt_q;
    logic              cb_q;         // borrow during SUB, carry during ADD
    logic              wrapped_q;
    logic              out_valid_q;

    addsub_mode_e      mode;
    chunk_t            op_a, op_b, res;
    logic              cout;
    logic              accept, last;

    assign accept = in_valid && (state_q == StIdle);
    assign last   = (cnt_q == CNT_LAST);

    // Single shared chunk unit: SUB consumes a/b, ADD folds p into the difference.
    always_comb begin
        mode = ModeAdd;
        op_a = diff_sr[CHUNK_W-1:0];
`ifdef MOD_SUB_CONST_TIME_EN
        op_b = wrapped_q ? p_sr[CHUNK_W-1:0] : '0;
`else
        op_b = p_sr[CHUNK_W-1:0];
`endif
        if (state_q == StSub) begin
            mode = ModeSub;
            op_a = a_sr[CHUNK_W-1:0];
            op_b = b_sr[CHUNK_W-1:0];
        end
    end

    chunk_addsub u_chunk_addsub (
        .mode   (mode),
        .a      (op_a),
        .b      (op_b),
        .cin    (cb_q),
        .result (res),
        .cout   (cout)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StSub;
            StSub: begin
                if (last) begin
`ifdef MOD_SUB_CONST_TIME_EN
                    state_d = StAdd;
`else
                    state_d = cout ? StAdd : StDone;
`endif
                end
            end
            StAdd:  if (last) state_d = StDone;
            StDone: if (out_valid_q && out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr        <= '0;
            b_sr        <= '0;
            p_sr        <= '0;
            diff_sr     <= '0;
            cnt_q       <= '0;
            cb_q        <= 1'b0;
            wrapped_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    out_valid_q <= 1'b0;
                    if (accept) begin
                        a_sr  <= {1'b0, a};
                        b_sr  <= {1'b0, b};
                        p_sr  <= {1'b0, p};
                        cnt_q <= '0;
                        cb_q  <= 1'b0;
                    end
                end
                StSub: begin
                    diff_sr <= {res, diff_sr[WORD_W-1:CHUNK_W]};
                    a_sr    <= a_sr >> CHUNK_W;
                    b_sr    <= b_sr >> CHUNK_W;
                    cb_q    <= cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        // Top-chunk borrow means a < b; ADD starts with a clean carry.
                        wrapped_q <= cout;
                        cb_q      <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                StAdd: begin
                    // Carry out of the top chunk is dropped: the sum wraps mod 2^256.
                    diff_sr <= {res, diff_sr[WORD_W-1:CHUNK_W]};
                    p_sr    <= p_sr >> CHUNK_W;
                    cb_q    <= cout;
                    cnt_q   <= cnt_q + 1'b1;
                end
                StDone: begin
                    out_valid_q <= !(out_valid_q && out_ready);
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign out       = diff_sr[OP_W-1:0];
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_mod_sub_serial.sv
// Self-checking bench for mod_sub_serial: directed cases plus randomized operands,
// compared against a whole-word arithmetic reference model.
module tb_mod_sub_serial;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [254:0] a, b, p;
    logic         out_valid;
    logic         out_ready;
    logic [254:0] out;
    logic         wrapped;

    int n_cmp = 0;
    int n_err = 0;

`ifdef MOD_SUB_CONST_TIME_EN
    localparam int LAT_NOWRAP = 9;
`else
    localparam int LAT_NOWRAP = 5;
`endif
    localparam int LAT_WRAP = 9;

    mod_sub_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [254:0] rand255();
        logic [255:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[254:0];
    endfunction

    // Reference: a - b as a 256-bit word, add p once if a < b, keep the low 255 bits.
    task automatic model(input logic [254:0] ma, input logic [254:0] mb, input logic [254:0] mp,
                         output logic [254:0] r, output logic w);
        logic [255:0] d;
        w = (ma < mb);
        d = {1'b0, ma} - {1'b0, mb};
        if (w) d = d + {1'b0, mp};
        r = d[254:0];
    endtask

    task automatic run_txn(input logic [254:0] ta, input logic [254:0] tb_v,
                           input logic [254:0] tp, input int hold, input string tag);
        logic [254:0] er;
        logic         ew;
        logic [254:0] snap_out;
        logic         snap_w;
        int           lat;
        model(ta, tb_v, tp, er, ew);
        check({tag, "_in_ready"}, {255'd0, in_ready}, 256'd1);
        a = ta;
        b = tb_v;
        p = tp;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble operands after acceptance; result must not depend on them.
        in_valid = 1'b0;
        a = rand255();
        b = rand255();
        p = rand255();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 256'(lat), 256'(ew ? LAT_WRAP : LAT_NOWRAP));
        check({tag, "_out"}, {1'b0, out}, {1'b0, er});
        check({tag, "_wrapped"}, {255'd0, wrapped}, {255'd0, ew});
        snap_out = out;
        snap_w   = wrapped;
        repeat (hold) begin
            in_valid = 1'b1;
            a = rand255();
            @(posedge clk);
            #1;
            check({tag, "_bp_valid"}, {255'd0, out_valid}, 256'd1);
            check({tag, "_bp_out"}, {1'b0, out}, {1'b0, snap_out});
            check({tag, "_bp_wrapped"}, {255'd0, wrapped}, {255'd0, snap_w});
            check({tag, "_bp_in_ready"}, {255'd0, in_ready}, 256'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, {255'd0, out_valid}, 256'd0);
        check({tag, "_post_in_ready"}, {255'd0, in_ready}, 256'd1);
    endtask

    initial begin
        logic [254:0] rp, ra, rb;
        logic         saw_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        p = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {255'd0, out_valid}, 256'd0);
        check("rst_in_ready", {255'd0, in_ready}, 256'd1);
        check("rst_out", {1'b0, out}, 256'd0);
        check("rst_wrapped", {255'd0, wrapped}, 256'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_txn(255'd10, 255'd3, 255'd13, 0, "nowrap");
        run_txn(255'd3, 255'd10, 255'd13, 0, "wrap");
        run_txn(255'd1 << 64, 255'd1, 255'd1 << 254, 0, "xborrow");
        run_txn(255'd0, 255'd1, 255'd0 - 255'd19, 0, "fullcarry");
        run_txn(255'd3, 255'd10, 255'd13, 3, "bp");
        run_txn(255'd5, 255'd5, 255'd7, 0, "equal");

        // Reset lands on the second SUB edge.
        a = 255'd3;
        b = 255'd10;
        p = 255'd13;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", {255'd0, out_valid}, 256'd0);
        check("midrst_in_ready", {255'd0, in_ready}, 256'd1);
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            saw_valid |= out_valid;
        end
        check("midrst_no_valid", {255'd0, saw_valid}, 256'd0);
        run_txn(255'd3, 255'd10, 255'd13, 0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 0) begin
                rp = 255'($urandom_range(1, 1000));
                ra = 255'($urandom_range(0, 999)) % rp;
                rb = 255'($urandom_range(0, 999)) % rp;
            end else if (i % 4 == 3) begin
                // Preconditions deliberately ignored.
                rp = rand255();
                ra = rand255();
                rb = rand255();
            end else begin
                rp = rand255() | 255'd1;
                ra = rand255() % rp;
                rb = rand255() % rp;
            end
            run_txn(ra, rb, rp, i % 3, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
